// File: rtl/cycle_timer.sv
// Prescaled free-running timestamp plus CH independent timeout channels with a sticky finish request.
// Optional per-channel timestamp capture is compiled in when TIMER_CAPTURE_EN is defined.

module cycle_timer_ch #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_tick,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_busy,
    output logic             o_expired,
    output logic             o_exp_nxt
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXP} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_lim, w_lim_nxt;
    logic             r_exp, w_exp_nxt;
    logic [CNT_W-1:0] w_inc;

    assign w_inc = r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lim   <= '0;
            r_exp   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lim   <= w_lim_nxt;
            r_exp   <= w_exp_nxt;
        end
    end

    // Priority: stop, then start (restart suppresses a coincident expiry), then counting.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lim_nxt   = r_lim;
        w_exp_nxt   = 1'b0;
        if (i_stop) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (i_start) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
            w_lim_nxt   = i_limit;
        end else if (r_state == S_RUN && i_en) begin
            if (r_lim == '0) begin
                w_state_nxt = S_EXP;
                w_exp_nxt   = 1'b1;
            end else if (i_tick) begin
                w_cnt_nxt = w_inc;
                if (w_inc == r_lim) begin
                    w_state_nxt = S_EXP;
                    w_exp_nxt   = 1'b1;
                end
            end
        end
    end

    assign o_busy    = (r_state == S_RUN);
    assign o_expired = r_exp;
    assign o_exp_nxt = w_exp_nxt;
endmodule

module cycle_timer #(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8,
    parameter int CH      = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic [PRESC_W-1:0]  i_presc_div,
    output logic                o_tick,
    output logic [CNT_W-1:0]    o_ts,
    output logic                o_ts_wrap,
    input  logic [CH-1:0]       i_ch_start,
    input  logic [CH-1:0]       i_ch_stop,
    input  logic [CH*CNT_W-1:0] i_ch_limit,
    output logic [CH-1:0]       o_ch_busy,
    output logic [CH-1:0]       o_ch_expired,
    output logic                o_finish_req,
    input  logic                i_finish_clr
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic [CH-1:0]       i_cap_evt,
    output logic [CH*CNT_W-1:0] o_cap_ts,
    output logic [CH-1:0]       o_cap_valid
`endif
);
    logic [PRESC_W-1:0] r_presc_cnt;
    logic               r_tick;
    logic [CNT_W-1:0]   r_ts;
    logic               r_ts_wrap;
    logic               r_finish;
    logic               w_fire;
    logic [CH-1:0]      w_exp_nxt;

    // >= lets a lowered divider take effect on the next enabled cycle.
    assign w_fire = i_en && (r_presc_cnt >= i_presc_div);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_presc_cnt <= '0;
            r_tick      <= 1'b0;
            r_ts        <= '0;
            r_ts_wrap   <= 1'b0;
        end else begin
            r_tick    <= w_fire;
            r_ts_wrap <= w_fire && (&r_ts);
            if (w_fire) begin
                r_presc_cnt <= '0;
                r_ts        <= r_ts + CNT_W'(1);
            end else if (i_en) begin
                r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < CH; g++) begin : g_ch
            cycle_timer_ch #(.CNT_W(CNT_W)) u_ch (
                .i_clk     (i_clk),
                .i_rst_n   (i_rst_n),
                .i_en      (i_en),
                .i_tick    (r_tick),
                .i_start   (i_ch_start[g]),
                .i_stop    (i_ch_stop[g]),
                .i_limit   (i_ch_limit[g*CNT_W +: CNT_W]),
                .o_busy    (o_ch_busy[g]),
                .o_expired (o_ch_expired[g]),
                .o_exp_nxt (w_exp_nxt[g])
            );
        end
    endgenerate

    // A new expiry outranks a coincident clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)         r_finish <= 1'b0;
        else if (|w_exp_nxt)  r_finish <= 1'b1;
        else if (i_finish_clr) r_finish <= 1'b0;
    end

`ifdef TIMER_CAPTURE_EN
    logic [CH*CNT_W-1:0] r_cap_ts;
    logic [CH-1:0]       r_cap_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cap_ts    <= '0;
            r_cap_valid <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (i_cap_evt[i]) begin
                    r_cap_ts[i*CNT_W +: CNT_W] <= r_ts;
                    r_cap_valid[i]             <= 1'b1;
                end else if (i_ch_start[i]) begin
                    r_cap_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign o_cap_ts    = r_cap_ts;
    assign o_cap_valid = r_cap_valid;
`endif

    assign o_tick       = r_tick;
    assign o_ts         = r_ts;
    assign o_ts_wrap    = r_ts_wrap;
    assign o_finish_req = r_finish;
endmodule

// File: tb/tb_cycle_timer.sv
// Directed bench for cycle_timer (CNT_W=4 so the timestamp wrap is reachable quickly).

module tb_cycle_timer;
    localparam int CNT_W   = 4;
    localparam int PRESC_W = 8;
    localparam int CH      = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic [PRESC_W-1:0]  presc_div;
    logic                tick;
    logic [CNT_W-1:0]    ts;
    logic                ts_wrap;
    logic [CH-1:0]       ch_start;
    logic [CH-1:0]       ch_stop;
    logic [CH*CNT_W-1:0] ch_limit;
    logic [CH-1:0]       ch_busy;
    logic [CH-1:0]       ch_expired;
    logic                finish_req;
    logic                finish_clr;
`ifdef TIMER_CAPTURE_EN
    logic [CH-1:0]       cap_evt;
    logic [CH*CNT_W-1:0] cap_ts;
    logic [CH-1:0]       cap_valid;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cycle_timer #(.CNT_W(CNT_W), .PRESC_W(PRESC_W), .CH(CH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_presc_div  (presc_div),
        .o_tick       (tick),
        .o_ts         (ts),
        .o_ts_wrap    (ts_wrap),
        .i_ch_start   (ch_start),
        .i_ch_stop    (ch_stop),
        .i_ch_limit   (ch_limit),
        .o_ch_busy    (ch_busy),
        .o_ch_expired (ch_expired),
        .o_finish_req (finish_req),
        .i_finish_clr (finish_clr)
`ifdef TIMER_CAPTURE_EN
        ,
        .i_cap_evt    (cap_evt),
        .o_cap_ts     (cap_ts),
        .o_cap_valid  (cap_valid)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold reset for two edges with strobes low; every output must read zero.
    task automatic do_reset();
        rst_n      = 1'b0;
        ch_start   = '0;
        ch_stop    = '0;
        finish_clr = 1'b0;
`ifdef TIMER_CAPTURE_EN
        cap_evt    = '0;
`endif
        step();
        step();
        chk("rst_tick", tick, 0);
        chk("rst_ts", ts, 0);
        chk("rst_wrap", ts_wrap, 0);
        chk("rst_busy", ch_busy, 0);
        chk("rst_exp", ch_expired, 0);
        chk("rst_fin", finish_req, 0);
`ifdef TIMER_CAPTURE_EN
        chk("rst_capv", cap_valid, 0);
        chk("rst_capts", cap_ts, 0);
`endif
    endtask

    initial begin
        ch_limit = '0;
        // Prescaler /5: tick after every 5th enabled edge, ts=10 at edge 50.
        en = 1'b1; presc_div = 8'd4;
        do_reset();
        rst_n = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            chk("s1_tick", tick, (k % 5 == 0) ? 1 : 0);
            chk("s1_ts", ts, k / 5);
        end

        // presc_div=0: ts counts every edge, wraps 15->0 at edge 16 with one pulse.
        presc_div = 8'd0;
        do_reset();
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("s2_ts", ts, k % 16);
            chk("s2_wrap", ts_wrap, (k == 16) ? 1 : 0);
        end

        // ch0 limit 3: busy for 3 cycles, one-cycle expiry, sticky finish until clear.
        do_reset();
        ch_limit[0 +: CNT_W] = 4'd3;
        ch_start = 4'b0001;
        rst_n = 1'b1;
        step(); ch_start = '0;
        chk("s3_busy1", ch_busy, 4'b0001);
        step();
        chk("s3_busy2", ch_busy, 4'b0001);
        step();
        chk("s3_busy3", ch_busy, 4'b0001);
        chk("s3_exp3", ch_expired, 0);
        chk("s3_fin3", finish_req, 0);
        step();
        chk("s3_busy4", ch_busy, 0);
        chk("s3_exp4", ch_expired, 4'b0001);
        chk("s3_fin4", finish_req, 1);
        step();
        chk("s3_exp5", ch_expired, 0);
        chk("s3_fin5", finish_req, 1);
        finish_clr = 1'b1;
        step(); finish_clr = 1'b0;
        chk("s3_fin_clr", finish_req, 0);

        // ch1 limit 10, restart at count 8 (edge 10); later limit change ignored; expiry at edge 20.
        do_reset();
        ch_limit[1*CNT_W +: CNT_W] = 4'd10;
        ch_start = 4'b0010;
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1) ch_start = '0;
            if (k == 9) ch_start = 4'b0010;
            if (k == 10) begin
                ch_start = '0;
                ch_limit[1*CNT_W +: CNT_W] = 4'd3;
            end
            chk("s4_busy", ch_busy, (k < 20) ? 4'b0010 : 4'b0000);
            chk("s4_exp", ch_expired, (k == 20) ? 4'b0010 : 4'b0000);
        end
        chk("s4_fin", finish_req, 1);
        step();
        chk("s4_exp_low", ch_expired, 0);
        finish_clr = 1'b1;
        step(); finish_clr = 1'b0;
        chk("s4_fin_clr", finish_req, 0);
        ch_start = 4'b0010;
        step();
        chk("s4_restart", ch_busy, 4'b0010);
        ch_stop = 4'b0010;
        step(); ch_start = '0; ch_stop = '0;
        chk("s4_stop_wins", ch_busy, 0);
        // ch0 limit 2, restart coincident with the expiring tick suppresses the pulse.
        ch_limit[0 +: CNT_W] = 4'd2;
        ch_start = 4'b0001;
        step(); ch_start = '0;
        chk("s4_c0_busy", ch_busy, 4'b0001);
        step();
        ch_start = 4'b0001;
        step(); ch_start = '0;
        chk("s4_c0_noexp", ch_expired, 0);
        chk("s4_c0_run", ch_busy, 4'b0001);
        step();
        finish_clr = 1'b1;
        step(); finish_clr = 1'b0;
        chk("s4_c0_exp", ch_expired, 4'b0001);
        chk("s4_fin_set_wins", finish_req, 1);

        // ch2 limit 0 held off by en=0, expires on the first enabled edge.
        en = 1'b0;
        do_reset();
        ch_limit[2*CNT_W +: CNT_W] = 4'd0;
        ch_start = 4'b0100;
        rst_n = 1'b1;
        step(); ch_start = '0;
        chk("s5_busy", ch_busy, 4'b0100);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("s5_hold_busy", ch_busy, 4'b0100);
            chk("s5_hold_exp", ch_expired, 0);
            chk("s5_hold_tick", tick, 0);
            chk("s5_hold_ts", ts, 0);
        end
        en = 1'b1;
        step();
        chk("s5_exp", ch_expired, 4'b0100);
        chk("s5_busy_off", ch_busy, 0);
        chk("s5_fin", finish_req, 1);

`ifdef TIMER_CAPTURE_EN
        // Capture ts=7 on ch3; start clears valid; capture beats a coincident start.
        do_reset();
        ch_limit[3*CNT_W +: CNT_W] = 4'd15;
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) step();
        cap_evt = 4'b1000;
        step(); cap_evt = '0;
        chk("s6_capts", cap_ts[3*CNT_W +: CNT_W], 7);
        chk("s6_capv", cap_valid, 4'b1000);
        ch_start = 4'b1000;
        step(); ch_start = '0;
        chk("s6_capv_clr", cap_valid, 0);
        chk("s6_capts_keep", cap_ts[3*CNT_W +: CNT_W], 7);
        cap_evt = 4'b1000; ch_start = 4'b1000;
        step(); cap_evt = '0; ch_start = '0;
        chk("s6_cap_wins", cap_valid, 4'b1000);
        chk("s6_capts2", cap_ts[3*CNT_W +: CNT_W], 9);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
